// File: rtl/player_state_engine.sv
// Per-player fighter update engine: frame-gated 3-stage next-state/timer/position pipeline.
// Optional PLAYER_INPUT_BUFFER_EN adds a one-entry button buffer for presses made during non-actionable frames.
module player_state_engine #(
  parameter int POSITION_DEPTH     = 10,
  parameter int SPRITE_INDEX_DEPTH = 4,
  parameter int KICK_FRAMES        = 6,
  parameter int GRAB_FRAMES        = 8,
  parameter int WALK_FRAMES        = 4,
  parameter int END_FRAMES         = 8,
  parameter int F_WALK_SPEED       = 4,
  parameter int B_WALK_SPEED       = 2,
  parameter int PLAYER_WIDTH       = 32,
  parameter int ARENA_MAX          = 639,
  parameter int START_POS_P1       = 100,
  parameter int START_POS_P2       = 500
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          frame_clk,
  input  logic [4:0]                    player_buttons,
  input  logic                          player_num,
  input  logic [POSITION_DEPTH-1:0]     other_player_position,
  input  logic                          player_attack_connected,
  input  logic                          opponent_attack_connected,
  output logic [2:0]                    next_state,
  output logic [SPRITE_INDEX_DEPTH-1:0] sprite_index,
  output logic [POSITION_DEPTH-1:0]     next_position,
  output logic                          done_gen
);

  localparam int PW1 = POSITION_DEPTH + 1;
  localparam int TW  = SPRITE_INDEX_DEPTH;

  localparam logic [2:0] S_NOTHING = 3'd0;
  localparam logic [2:0] S_WALK_F  = 3'd1;
  localparam logic [2:0] S_WALK_B  = 3'd2;
  localparam logic [2:0] S_BLOCK   = 3'd3;
  localparam logic [2:0] S_KICK    = 3'd4;
  localparam logic [2:0] S_GRAB    = 3'd5;
  localparam logic [2:0] S_WIN     = 3'd6;
  localparam logic [2:0] S_LOSE    = 3'd7;

  localparam int K_BUTTON  = 0;
  localparam int B_BUTTON  = 1;
  localparam int G_BUTTON  = 2;
  localparam int WB_BUTTON = 3;
  localparam int WF_BUTTON = 4;

  localparam logic [PW1-1:0] ARENA_HI  = PW1'(ARENA_MAX - PLAYER_WIDTH + 1);
  localparam logic [PW1-1:0] PW_EXT    = PW1'(PLAYER_WIDTH);
  localparam logic [PW1-1:0] F_STEP    = PW1'(F_WALK_SPEED);
  localparam logic [PW1-1:0] B_STEP    = PW1'(B_WALK_SPEED);
  localparam logic [TW-1:0]  KICK_LAST = TW'(KICK_FRAMES - 1);
  localparam logic [TW-1:0]  GRAB_LAST = TW'(GRAB_FRAMES - 1);
  localparam logic [TW-1:0]  WALK_LAST = TW'(WALK_FRAMES - 1);
  localparam logic [TW-1:0]  END_LAST  = TW'(END_FRAMES - 1);

  // Synchroniser and edge detector
  logic [1:0]                r_sync;
  logic                      r_sync_d;

  // Pipeline valid flags for T+1, T+2, T+3
  logic                      r_v1;
  logic                      r_v2;
  logic                      r_v3;

  // Frame snapshot
  logic [4:0]                r_btn;
  logic [POSITION_DEPTH-1:0] r_other;
  logic                      r_hit_own;
  logic                      r_hit_opp;
  logic                      r_snap_own;
  logic                      r_snap_opp;

  // Decision and committed state
  logic [2:0]                r_dec;
  logic [2:0]                r_state;
  logic [TW-1:0]             r_timer;
  logic [POSITION_DEPTH-1:0] r_pos;
  logic                      r_done;

  logic                      w_busy;
  logic                      w_tick;
  logic                      w_actionable;
  logic                      w_terminal;
  logic [4:0]                w_btn_eff;
  logic [2:0]                w_btn_state;
  logic [2:0]                w_dec;
  logic [TW-1:0]             w_last;
  logic [TW-1:0]             w_timer_next;
  logic                      w_moving;
  logic                      w_inc;
  logic [PW1-1:0]            w_step;
  logic [PW1-1:0]            w_pos_ext;
  logic [PW1-1:0]            w_other_ext;
  logic [PW1-1:0]            w_raw;
  logic [PW1-1:0]            w_arena;
  logic [PW1-1:0]            w_lim;
  logic [PW1-1:0]            w_col;

  assign w_busy = r_v1 | r_v2 | r_v3;
  assign w_tick = r_sync[1] & ~r_sync_d & ~w_busy;

  // The synchroniser keeps tracking through reset so a level held across reset is not seen as a new edge.
  always_ff @(posedge sys_clk) begin
    r_sync   <= {r_sync[0], frame_clk};
    r_sync_d <= r_sync[1];
  end

  always_comb begin
    w_actionable = 1'b0;
    case (r_state)
      S_NOTHING, S_WALK_F, S_WALK_B, S_BLOCK: w_actionable = 1'b1;
      S_KICK:                                 w_actionable = (r_timer == KICK_LAST);
      S_GRAB:                                 w_actionable = (r_timer == GRAB_LAST);
      default:                                w_actionable = 1'b0;
    endcase
  end

  assign w_terminal = (r_state == S_WIN) || (r_state == S_LOSE);

`ifdef PLAYER_INPUT_BUFFER_EN
  logic [4:0] r_buf;
  logic [1:0] r_buf_age;
  logic [4:0] w_btn_top;

  always_comb begin
    w_btn_top = '0;
    if (r_btn[K_BUTTON])       w_btn_top[K_BUTTON]  = 1'b1;
    else if (r_btn[B_BUTTON])  w_btn_top[B_BUTTON]  = 1'b1;
    else if (r_btn[G_BUTTON])  w_btn_top[G_BUTTON]  = 1'b1;
    else if (r_btn[WB_BUTTON]) w_btn_top[WB_BUTTON] = 1'b1;
    else if (r_btn[WF_BUTTON]) w_btn_top[WF_BUTTON] = 1'b1;
  end

  assign w_btn_eff = (w_actionable && (r_btn == '0)) ? r_buf : r_btn;

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_buf     <= '0;
      r_buf_age <= '0;
    end else if (r_v1) begin
      if ((w_dec == S_WIN) || (w_dec == S_LOSE) || w_actionable) begin
        r_buf     <= '0;
        r_buf_age <= '0;
      end else if (w_btn_top != '0) begin
        r_buf     <= w_btn_top;
        r_buf_age <= '0;
      end else if (r_buf != '0) begin
        if (r_buf_age == 2'd2) begin
          r_buf     <= '0;
          r_buf_age <= '0;
        end else begin
          r_buf_age <= r_buf_age + 2'd1;
        end
      end
    end
  end
`else
  assign w_btn_eff = r_btn;
`endif

  always_comb begin
    if (w_btn_eff[K_BUTTON])       w_btn_state = S_KICK;
    else if (w_btn_eff[B_BUTTON])  w_btn_state = S_BLOCK;
    else if (w_btn_eff[G_BUTTON])  w_btn_state = S_GRAB;
    else if (w_btn_eff[WB_BUTTON]) w_btn_state = S_WALK_B;
    else if (w_btn_eff[WF_BUTTON]) w_btn_state = S_WALK_F;
    else                           w_btn_state = S_NOTHING;
  end

  // A block absorbs the opponent's hit entirely; the frame then resolves as if no hit arrived.
  always_comb begin
    if (w_terminal)                                 w_dec = r_state;
    else if (r_snap_own && r_snap_opp)              w_dec = S_LOSE;
    else if (r_snap_own)                            w_dec = S_WIN;
    else if (r_snap_opp && (r_state != S_BLOCK))    w_dec = S_LOSE;
    else if (!w_actionable)                         w_dec = r_state;
    else                                            w_dec = w_btn_state;
  end

  always_comb begin
    case (r_dec)
      S_WALK_F, S_WALK_B: w_last = WALK_LAST;
      S_KICK:             w_last = KICK_LAST;
      S_GRAB:             w_last = GRAB_LAST;
      default:            w_last = '0;
    endcase
  end

  always_comb begin
    if (r_dec != r_state)
      w_timer_next = '0;
    else if ((r_dec == S_WIN) || (r_dec == S_LOSE))
      w_timer_next = (r_timer == END_LAST) ? r_timer : r_timer + TW'(1);
    else
      w_timer_next = (r_timer == w_last) ? '0 : r_timer + TW'(1);
  end

  assign w_moving    = (r_dec == S_WALK_F) || (r_dec == S_WALK_B);
  assign w_inc       = (r_dec == S_WALK_F) ^ player_num;
  assign w_step      = (r_dec == S_WALK_F) ? F_STEP : B_STEP;
  assign w_pos_ext   = {1'b0, r_pos};
  assign w_other_ext = {1'b0, r_other};

  always_comb begin
    if (!w_moving)
      w_raw = w_pos_ext;
    else if (w_inc)
      w_raw = w_pos_ext + w_step;
    else
      w_raw = (w_pos_ext < w_step) ? '0 : w_pos_ext - w_step;

    w_arena = (w_raw > ARENA_HI) ? ARENA_HI : w_raw;

    if (!player_num) begin
      w_lim = (w_other_ext < PW_EXT) ? '0 : w_other_ext - PW_EXT;
      w_col = (w_arena > w_lim) ? w_lim : w_arena;
    end else begin
      w_lim = w_other_ext + PW_EXT;
      w_col = (w_arena < w_lim) ? w_lim : w_arena;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_btn      <= '0;
      r_other    <= '0;
      r_hit_own  <= 1'b0;
      r_hit_opp  <= 1'b0;
      r_snap_own <= 1'b0;
      r_snap_opp <= 1'b0;
      r_dec      <= S_NOTHING;
      r_state    <= S_NOTHING;
      r_timer    <= '0;
      r_pos      <= player_num ? POSITION_DEPTH'(START_POS_P2) : POSITION_DEPTH'(START_POS_P1);
      r_done     <= 1'b0;
    end else begin
      r_v1      <= w_tick;
      r_v2      <= r_v1;
      r_v3      <= r_v2;
      r_hit_own <= (r_hit_own & ~w_tick) | player_attack_connected;
      r_hit_opp <= (r_hit_opp & ~w_tick) | opponent_attack_connected;
      if (w_tick) begin
        r_btn      <= player_buttons;
        r_other    <= other_player_position;
        r_snap_own <= r_hit_own;
        r_snap_opp <= r_hit_opp;
        r_done     <= 1'b0;
      end
      if (r_v1)
        r_dec <= w_dec;
      if (r_v2) begin
        r_state <= r_dec;
        r_timer <= w_timer_next;
        r_pos   <= w_col[PW1-1] ? '1 : w_col[POSITION_DEPTH-1:0];
        r_done  <= 1'b1;
      end
    end
  end

  assign next_state    = r_state;
  assign sprite_index  = r_timer;
  assign next_position = r_pos;
  assign done_gen      = r_done;

endmodule
